// File: rtl/interrupt_drain_sequencer_pkg.sv
// rtl/interrupt_drain_sequencer_pkg.sv - shared types and default sizes for the interrupt drain sequencer
package interrupt_drain_sequencer_pkg;

  localparam int DEF_NUM_IRQ         = 8;
  localparam int DEF_CAUSE_W         = 3;
  localparam int DEF_COOLDOWN_CYCLES = 4;
  localparam int DEF_DRAIN_CNT_W     = 16;

  // Sequencer phases: wait for an interrupt, drain the pipeline, confirm empty,
  // present the trap, then hold off new interrupts for a short window.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    SETTLE   = 3'd2,
    TRAP     = 3'd3,
    COOLDOWN = 3'd4
  } int_seq_state_e;

endpackage

// File: rtl/interrupt_drain_sequencer_prio_enc.sv
// rtl/interrupt_drain_sequencer_prio_enc.sv - lowest-index-wins priority encoder for masked interrupt lines
module interrupt_priority_encoder
  import interrupt_drain_sequencer_pkg::*;
#(
  parameter int NUM_IRQ = DEF_NUM_IRQ,
  parameter int CAUSE_W = DEF_CAUSE_W
) (
  input  logic [NUM_IRQ-1:0] masked,
  output logic [CAUSE_W-1:0] index,
  output logic               valid
);

  // Scan from the top so the lowest set bit is the last one written and wins.
  always_comb begin
    index = '0;
    valid = |masked;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (masked[i]) begin
        index = CAUSE_W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_drain_sequencer.sv
// rtl/interrupt_drain_sequencer.sv - drains the pipeline and hands one trap request per interrupt to recovery
module interrupt_drain_sequencer
  import interrupt_drain_sequencer_pkg::*;
#(
  parameter int NUM_IRQ         = DEF_NUM_IRQ,
  parameter int CAUSE_W         = DEF_CAUSE_W,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int DRAIN_CNT_W     = DEF_DRAIN_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_IRQ-1:0]     irqPending,
  input  logic [NUM_IRQ-1:0]     irqEnable,
  input  logic                   globalIntEnable,
  input  logic                   wholePipelineEmpty,
  input  logic                   trapAck,
  output logic                   npStageSendBubbleLowerForInterrupt,
  output logic                   takeInterrupt,
  output logic [CAUSE_W-1:0]     interruptCause,
  output logic                   busy,
  output logic [DRAIN_CNT_W-1:0] drainCycles
);

  // Counter is at least one bit wide so a zero-length cooldown still elaborates.
  localparam int CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES + 1) : 1;

  int_seq_state_e            state_q;
  int_seq_state_e            state_d;
  logic [CD_W-1:0]           cooldown_q;
  logic [CAUSE_W-1:0]        cause_q;
  logic [DRAIN_CNT_W-1:0]    drain_q;
  logic [NUM_IRQ-1:0]        masked_irq;
  logic [CAUSE_W-1:0]        enc_index;
  logic                      enc_valid;
  logic                      active;

  assign masked_irq = irqPending & irqEnable;
  assign active     = globalIntEnable & enc_valid;

  interrupt_priority_encoder #(
    .NUM_IRQ (NUM_IRQ),
    .CAUSE_W (CAUSE_W)
  ) u_prio_enc (
    .masked (masked_irq),
    .index  (enc_index),
    .valid  (enc_valid)
  );

  // State register; reset drops any drain or trap in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection plus Moore output decode from the registered state.
  always_comb begin
    state_d                            = state_q;
    npStageSendBubbleLowerForInterrupt = 1'b0;
    takeInterrupt                      = 1'b0;
    busy                               = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (active) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        npStageSendBubbleLowerForInterrupt = 1'b1;
        // Losing the interrupt takes precedence over seeing the pipeline empty.
        if (!active) begin
          state_d = IDLE;
        end else if (wholePipelineEmpty) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        npStageSendBubbleLowerForInterrupt = 1'b1;
        if (!active) begin
          state_d = IDLE;
        end else if (!wholePipelineEmpty) begin
          state_d = DRAIN;
        end else begin
          state_d = TRAP;
        end
      end
      TRAP: begin
        // Once presented the trap cannot be withdrawn; only the ack moves on.
        npStageSendBubbleLowerForInterrupt = 1'b1;
        takeInterrupt                      = 1'b1;
        if (trapAck) begin
          state_d = (COOLDOWN_CYCLES == 0) ? IDLE : COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (cooldown_q <= CD_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Cooldown counter: loaded on the acknowledged trap, counts down to the exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cooldown_q <= '0;
    end else if (state_q == TRAP && state_d == COOLDOWN) begin
      cooldown_q <= CD_W'(COOLDOWN_CYCLES);
    end else if (state_q == COOLDOWN && cooldown_q != '0) begin
      cooldown_q <= cooldown_q - 1'b1;
    end
  end

  // Drain performance counter: restarts when a new drain begins, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_q <= '0;
    end else if (state_q == IDLE && state_d == DRAIN) begin
      drain_q <= '0;
    end else if (state_q == DRAIN && drain_q != '1) begin
      drain_q <= drain_q + 1'b1;
    end
  end

  // Cause register: captured as the trap is entered and held everywhere else.
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q <= '0;
    end else if (state_q == SETTLE && state_d == TRAP) begin
      cause_q <= enc_index;
    end
  end

  assign interruptCause = cause_q;
  assign drainCycles    = drain_q;

endmodule

// File: tb/tb_interrupt_drain_sequencer.sv
// tb/tb_interrupt_drain_sequencer.sv - self-checking bench for interrupt_drain_sequencer
module tb_interrupt_drain_sequencer;

  localparam int NUM_IRQ  = 8;
  localparam int CAUSE_W  = 3;
  localparam int CD       = 4;
  localparam int DW       = 16;
  localparam int DRAIN_MAX = (1 << DW) - 1;

  localparam int P_IDLE = 0, P_DRAIN = 1, P_SETTLE = 2, P_TRAP = 3, P_COOL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [NUM_IRQ-1:0] irq_pending;
  logic [NUM_IRQ-1:0] irq_enable;
  logic               gie;
  logic               empty;
  logic               ack;
  logic               bubble;
  logic               take;
  logic [CAUSE_W-1:0] cause;
  logic               busy;
  logic [DW-1:0]      drain;

  int checks = 0;
  int errors = 0;

  int m_phase = P_IDLE;
  int m_cd    = 0;
  int m_drain = 0;
  int m_cause = 0;
  bit m_valid = 1'b0;

  interrupt_drain_sequencer #(
    .NUM_IRQ         (NUM_IRQ),
    .CAUSE_W         (CAUSE_W),
    .COOLDOWN_CYCLES (CD),
    .DRAIN_CNT_W     (DW)
  ) dut (
    .clk                                (clk),
    .rst                                (rst),
    .irqPending                         (irq_pending),
    .irqEnable                          (irq_enable),
    .globalIntEnable                    (gie),
    .wholePipelineEmpty                 (empty),
    .trapAck                            (ack),
    .npStageSendBubbleLowerForInterrupt (bubble),
    .takeInterrupt                      (take),
    .interruptCause                     (cause),
    .busy                               (busy),
    .drainCycles                        (drain)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_set(input logic [NUM_IRQ-1:0] v);
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // Reference behaviour: one step per clock edge from the inputs present at that edge.
  task automatic model_step();
    bit act;
    act = gie && ((irq_pending & irq_enable) != '0);
    if (rst) begin
      m_phase = P_IDLE;
      m_cd    = 0;
      m_drain = 0;
      m_cause = 0;
      m_valid = 1'b1;
    end else begin
      case (m_phase)
        P_IDLE: if (act) begin
          m_phase = P_DRAIN;
          m_drain = 0;
        end
        P_DRAIN: begin
          m_drain = (m_drain < DRAIN_MAX) ? m_drain + 1 : DRAIN_MAX;
          if (!act) m_phase = P_IDLE;
          else if (empty) m_phase = P_SETTLE;
        end
        P_SETTLE: begin
          if (!act) m_phase = P_IDLE;
          else if (!empty) m_phase = P_DRAIN;
          else begin
            m_phase = P_TRAP;
            m_cause = lowest_set(irq_pending & irq_enable);
          end
        end
        P_TRAP: if (ack) begin
          if (CD == 0) m_phase = P_IDLE;
          else begin
            m_phase = P_COOL;
            m_cd    = CD;
          end
        end
        default: begin
          if (m_cd <= 1) m_phase = P_IDLE;
          else m_cd = m_cd - 1;
        end
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Every-cycle comparison of all outputs against the reference.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_bubble", int'(bubble),
          int'(m_phase == P_DRAIN || m_phase == P_SETTLE || m_phase == P_TRAP));
      chk("model_take", int'(take), int'(m_phase == P_TRAP));
      chk("model_busy", int'(busy), int'(m_phase != P_IDLE));
      chk("model_cause", int'(cause), m_cause);
      chk("model_drain", int'(drain), m_drain);
    end
  end

  task automatic wait_take(input int max_cycles);
    int n = 0;
    while (take !== 1'b1 && n < max_cycles) begin
      cycle();
      n++;
    end
    chk("wait_take_bound", int'(take === 1'b1), 1);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin
      cycle();
      n++;
    end
    chk("wait_idle_bound", int'(busy === 1'b0), 1);
  endtask

  task automatic run_trap(input logic [NUM_IRQ-1:0] p, input logic [NUM_IRQ-1:0] e,
                          input int exp_cause, input string name);
    irq_pending = p;
    irq_enable  = e;
    gie         = 1'b1;
    empty       = 1'b1;
    wait_take(20);
    chk(name, int'(cause), exp_cause);
    irq_pending = '0;
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    wait_idle(20);
  endtask

  initial begin
    rst = 1'b1; irq_pending = '0; irq_enable = '0; gie = 1'b0; empty = 1'b0; ack = 1'b0;
    cycle();
    cycle();
    chk("reset_bubble", int'(bubble), 0);
    chk("reset_take", int'(take), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cause", int'(cause), 0);
    chk("reset_drain", int'(drain), 0);
    rst = 1'b0;
    cycle();

    // Basic timing
    irq_pending = 8'h04; irq_enable = 8'hFF; gie = 1'b1; empty = 1'b0;
    cycle();
    chk("t1_bubble", int'(bubble), 1);
    chk("t1_take", int'(take), 0);
    empty = 1'b1;
    cycle();
    chk("t2_take", int'(take), 0);
    cycle();
    chk("t3_take", int'(take), 1);
    chk("t3_cause", int'(cause), 2);
    cycle();
    cycle();
    ack = 1'b1;
    cycle();
    chk("t6_bubble", int'(bubble), 0);
    chk("t6_take", int'(take), 0);
    chk("t6_busy", int'(busy), 1);
    ack = 1'b0; irq_pending = '0;
    repeat (3) cycle();
    chk("t9_busy", int'(busy), 1);
    cycle();
    chk("t10_busy", int'(busy), 0);
    cycle();

    // Priority
    run_trap(8'h90, 8'hF0, 4, "prio_cause_4");
    run_trap(8'h90, 8'h80, 7, "prio_cause_7");

    // Abort after five drain cycles
    irq_pending = 8'h01; irq_enable = 8'hFF; gie = 1'b1; empty = 1'b0;
    repeat (5) cycle();
    irq_pending = '0;
    cycle();
    chk("abort_busy", int'(busy), 0);
    chk("abort_bubble", int'(bubble), 0);
    chk("abort_take", int'(take), 0);
    chk("abort_drain", int'(drain), 5);
    cycle();

    // Empty glitch
    irq_pending = 8'h08; empty = 1'b0;
    cycle();
    empty = 1'b1;
    cycle();
    empty = 1'b0;
    cycle();
    chk("glitch_redrain_bubble", int'(bubble), 1);
    chk("glitch_redrain_take", int'(take), 0);
    empty = 1'b1;
    cycle();
    chk("glitch_settle_take", int'(take), 0);
    cycle();
    chk("glitch_trap_take", int'(take), 1);
    chk("glitch_trap_cause", int'(cause), 3);
    irq_pending = '0; ack = 1'b1;
    cycle();
    ack = 1'b0;
    wait_idle(20);

    // Trap holds through input changes until a late ack
    irq_pending = 8'h20; irq_enable = 8'hFF; empty = 1'b1;
    wait_take(20);
    irq_pending = '0; irq_enable = 8'h55;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("hold_take", int'(take), 1);
      chk("hold_cause", int'(cause), 5);
    end
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    wait_idle(20);
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    chk("idle_ack_busy", int'(busy), 0);
    chk("idle_ack_take", int'(take), 0);
    cycle();
    chk("idle_ack_busy2", int'(busy), 0);

    // Reset during trap, then a clean restart
    irq_pending = 8'h02; irq_enable = 8'hFF; empty = 1'b1;
    wait_take(20);
    rst = 1'b1;
    cycle();
    chk("rst_trap_take", int'(take), 0);
    chk("rst_trap_bubble", int'(bubble), 0);
    chk("rst_trap_busy", int'(busy), 0);
    chk("rst_trap_cause", int'(cause), 0);
    rst = 1'b0; empty = 1'b0;
    cycle();
    chk("restart_busy", int'(busy), 1);
    chk("restart_drain0", int'(drain), 0);
    cycle();
    chk("restart_drain1", int'(drain), 1);
    irq_pending = '0;
    cycle();
    wait_idle(20);

    // Randomised traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)
        irq_pending = ($urandom_range(0, 1) != 0) ? NUM_IRQ'($urandom) : '0;
      if ($urandom_range(0, 15) == 0)
        irq_enable = NUM_IRQ'($urandom);
      gie   = ($urandom_range(0, 9) != 0);
      empty = ($urandom_range(0, 2) != 0);
      ack   = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0; ack = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
